// File: rtl/perceptron_pkg.sv
// perceptron_pkg
// Shared types and constants for the perceptron control blocks.
//   DATA_W      : width of every x, w and accumulated value (8-bit, wraps)
//   PAIR_W      : width of one packed x/w pair as stored in the register file
//   seq_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   pair_t      : one input/weight pair, x in the upper byte, w in the lower
//   addr_width  : index width for a table of `depth` entries, never below 1
package perceptron_pkg;

    localparam int DATA_W = 8;
    localparam int PAIR_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] w;
    } pair_t;

    // A single-entry table still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/perceptron_regfile.sv
// perceptron_regfile
// Small register file holding the x/w pairs of one inference.
// Ports:
//   clk, rst : clock and synchronous active-high clear of every entry
//   wr_en    : write strobe, wr_data lands in entry wr_addr at the clock edge
//   wr_addr  : write index; indices at or beyond DEPTH are dropped
//   wr_data  : packed pair {x, w}
//   rd_addr  : asynchronous read index
//   rd_data  : packed pair at rd_addr (zero for out-of-range indices)
module perceptron_regfile
    import perceptron_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [PAIR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [PAIR_W-1:0] rd_data
);

    logic [PAIR_W-1:0] mem_q [DEPTH];
    logic [PAIR_W-1:0] mem_d [DEPTH];

    // Next contents: unchanged except for the addressed entry on a write.
    // The range check matters only when DEPTH is not a power of two.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage with synchronous clear so a reset leaves all pairs at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read so the sequencer can register the next operand
    // in the same cycle it decides to advance.
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < DEPTH) begin
            rd_data = mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer
// Initiator side of an external multi-cycle MAC: steps through N_INPUTS
// x/w pairs, feeds the running sum back as mac_prev, captures mac_out once
// the MAC pipeline has settled, then applies a step threshold.
// Parameters:
//   N_INPUTS    : pairs per inference (1..16)
//   MAC_LATENCY : register stages from MAC operands to mac_out
//   THRESH      : unsigned step threshold, y = (y_acc >= THRESH)
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   load_en/load_addr/load_x/load_w   : register file write, honoured in IDLE only
//   start                             : begin an inference, honoured in IDLE only
//   mac_x, mac_w, mac_prev            : registered MAC operands
//   mac_out                           : MAC result
//   busy                              : inference in progress (RUN and DONE)
//   done                              : one-cycle pulse, coincident with new y/y_acc
//   y, y_acc                          : activation and final 8-bit dot product
module perceptron_sequencer
    import perceptron_pkg::*;
#(
    parameter int                N_INPUTS    = 4,
    parameter int                MAC_LATENCY = 3,
    parameter logic [DATA_W-1:0] THRESH      = 8'd64,
    localparam int               AW          = addr_width(N_INPUTS),
    localparam int               CW          = addr_width(MAC_LATENCY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_x,
    input  logic [DATA_W-1:0] load_w,
    input  logic              start,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_w,
    output logic [DATA_W-1:0] mac_prev,
    input  logic [DATA_W-1:0] mac_out,
    output logic              busy,
    output logic              done,
    output logic              y,
    output logic [DATA_W-1:0] y_acc
);

    seq_state_t        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mac_x_q, mac_x_d;
    logic [DATA_W-1:0] mac_w_q, mac_w_d;
    logic [DATA_W-1:0] mac_prev_q, mac_prev_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              y_q, y_d;
    logic [DATA_W-1:0] y_acc_q, y_acc_d;

    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic [PAIR_W-1:0] rd_data;
    pair_t             rd_pair;
    pair_t             first_pair;
    logic              step_end;
    logic              last_pair;

    // The pair table is frozen for the whole inference.
    assign wr_en = load_en && (state_q == IDLE);

    perceptron_regfile #(
        .DEPTH (N_INPUTS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (load_addr),
        .wr_data ({load_x, load_w}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_pair = pair_t'(rd_data);

    // A write to entry 0 in the start cycle lands at the same edge that
    // registers pair 0, so it is forwarded around the register file.
    assign first_pair = (wr_en && (load_addr == '0)) ? pair_t'({load_x, load_w}) : rd_pair;

    assign step_end  = (cnt_q == CW'(MAC_LATENCY));
    assign last_pair = (idx_q == AW'(N_INPUTS - 1));

    // Next-state and output decode. The read port looks at entry 0 while
    // idle and at the following entry while running, so the next operands
    // are ready at the edge that ends the current step.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mac_x_d    = mac_x_q;
        mac_w_d    = mac_w_q;
        mac_prev_d = mac_prev_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        y_d        = y_q;
        y_acc_d    = y_acc_q;
        rd_addr    = '0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    idx_d      = '0;
                    cnt_d      = '0;
                    acc_d      = '0;
                    mac_x_d    = first_pair.x;
                    mac_w_d    = first_pair.w;
                    mac_prev_d = '0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end

            RUN: begin
                rd_addr = idx_q + AW'(1);
                if (step_end) begin
                    cnt_d = '0;
                    acc_d = mac_out;
                    if (last_pair) begin
                        // Results are published on entry to DONE so that
                        // done and the new y/y_acc appear in the same cycle.
                        done_d  = 1'b1;
                        y_acc_d = mac_out;
                        y_d     = (mac_out >= THRESH);
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + AW'(1);
                        mac_x_d    = rd_pair.x;
                        mac_w_d    = rd_pair.w;
                        mac_prev_d = mac_out;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any inference silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mac_x_q    <= '0;
            mac_w_q    <= '0;
            mac_prev_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            y_q        <= 1'b0;
            y_acc_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mac_x_q    <= mac_x_d;
            mac_w_q    <= mac_w_d;
            mac_prev_q <= mac_prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            y_q        <= y_d;
            y_acc_q    <= y_acc_d;
        end
    end

    assign mac_x    = mac_x_q;
    assign mac_w    = mac_w_q;
    assign mac_prev = mac_prev_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign y        = y_q;
    assign y_acc    = y_acc_q;

endmodule

// File: tb/tb_perceptron_sequencer.sv
// tb_perceptron_sequencer
// Drives perceptron_sequencer against a behavioural 3-stage MAC. Each start
// pushes its hand-computed result and due cycle onto a scoreboard; a monitor
// pops and compares whenever done is seen.
module tb_perceptron_sequencer;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int P   = LAT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_en = 1'b0;
    logic [1:0] load_addr = '0;
    logic [7:0] load_x = '0;
    logic [7:0] load_w = '0;
    logic       start = 1'b0;
    logic [7:0] mac_x, mac_w, mac_prev, mac_out, y_acc;
    logic       busy, done, y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    typedef struct {
        logic [7:0] acc;
        logic       yv;
        int         due;
    } exp_t;

    exp_t sb[$];

    perceptron_sequencer #(
        .N_INPUTS    (N),
        .MAC_LATENCY (LAT),
        .THRESH      (8'd64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_x    (load_x),
        .load_w    (load_w),
        .start     (start),
        .mac_x     (mac_x),
        .mac_w     (mac_w),
        .mac_prev  (mac_prev),
        .mac_out   (mac_out),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .y_acc     (y_acc)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: three register stages, 8-bit wrap-around.
    logic [7:0] s1 = '0, s2 = '0, s3 = '0;
    always @(posedge clk) begin
        s1 <= mac_x * mac_w + mac_prev;
        s2 <= s1;
        s3 <= s2;
    end
    assign mac_out = s3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_count++;
            checkOutput("done_single_pulse", int'(prev_done), 0);
            checkOutput("busy_during_done", int'(busy), 1);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("y_acc", int'(y_acc), int'(e.acc));
                checkOutput("y", int'(y), int'(e.yv));
                checkOutput("done_latency", cyc, e.due);
            end
        end
        prev_done = done;
    end

    task automatic loadPair(input logic [1:0] addr, input logic [7:0] x, input logic [7:0] w);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_x    = x;
        load_w    = w;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic loadAll(input logic [7:0] x0, x1, x2, x3, input logic [7:0] w0, w1, w2, w3);
        loadPair(2'd0, x0, w0);
        loadPair(2'd1, x1, w1);
        loadPair(2'd2, x2, w2);
        loadPair(2'd3, x3, w3);
    endtask

    // Issues one start (optionally with a same-cycle load) and records the
    // expected result. Returns with s_cyc equal to the cycle count right
    // after the start edge.
    task automatic applyStimulus(input logic with_load, input logic [1:0] addr,
                                 input logic [7:0] x, input logic [7:0] w,
                                 input logic expect_done, input logic [7:0] exp_acc,
                                 input logic exp_y, output int s_cyc);
        @(negedge clk);
        start     = 1'b1;
        load_en   = with_load;
        load_addr = addr;
        load_x    = x;
        load_w    = w;
        s_cyc     = cyc + 1;
        if (expect_done) sb.push_back('{exp_acc, exp_y, s_cyc + N * P});
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
    endtask

    task automatic waitToCycle(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic waitDone();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_completes_in_time", int'(n < 60), 1);
        @(negedge clk);
    endtask

    initial begin
        int s;
        logic [7:0] prev_exp [4];
        logic [7:0] x_exp [4];
        prev_exp = '{8'd0, 8'd2, 8'd6, 8'd12};
        x_exp    = '{8'd1, 8'd2, 8'd3, 8'd4};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_y", int'(y), 0);
        checkOutput("reset_y_acc", int'(y_acc), 0);
        checkOutput("reset_mac_prev", int'(mac_prev), 0);

        $display("[TB] basic dot product");
        loadAll(8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd2, 8'd2, 8'd2);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd20, 1'b0, s);
        for (int k = 0; k < 4; k++) begin
            waitToCycle(s + k * P + 1);
            checkOutput("mac_prev_seq", int'(mac_prev), int'(prev_exp[k]));
            checkOutput("mac_x_seq", int'(mac_x), int'(x_exp[k]));
        end
        waitDone();

        $display("[TB] threshold boundary");
        loadAll(8'd8, 8'd8, 8'd0, 8'd0, 8'd4, 8'd4, 8'd0, 8'd0);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd64, 1'b1, s);
        waitDone();
        loadPair(2'd1, 8'd8, 8'd3);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd56, 1'b0, s);
        waitDone();

        $display("[TB] wrap-around");
        loadAll(8'd16, 8'd16, 8'd1, 8'd0, 8'd16, 8'd16, 8'd5, 8'd0);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd5, 1'b0, s);
        waitDone();

        $display("[TB] start and load while busy");
        loadAll(8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd2, 8'd2, 8'd2);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd20, 1'b0, s);
        waitToCycle(s + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitToCycle(s + 4);
        load_en = 1'b1; load_addr = 2'd0; load_x = 8'd100; load_w = 8'd100;
        @(negedge clk);
        load_en = 1'b0;
        waitToCycle(s + 9);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone();
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd20, 1'b0, s);
        waitDone();

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, s);
        waitToCycle(s + 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_mac_x", int'(mac_x), 0);
        checkOutput("midrst_mac_w", int'(mac_w), 0);
        checkOutput("midrst_mac_prev", int'(mac_prev), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_done", int'(done), 0);
        checkOutput("midrst_y", int'(y), 0);
        checkOutput("midrst_y_acc", int'(y_acc), 0);
        repeat (20) @(negedge clk);
        applyStimulus(1'b0, 2'd0, 8'd0, 8'd0, 1'b1, 8'd0, 1'b0, s);
        waitDone();

        $display("[TB] same-cycle load and start");
        applyStimulus(1'b1, 2'd0, 8'd10, 8'd10, 1'b1, 8'd100, 1'b1, s);
        waitDone();

        repeat (4) @(negedge clk);
        checkOutput("done_count", done_count, 8);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_sequencer.md
# perceptron_sequencer

Control block that drives one external `mac` unit to compute a full perceptron dot product and activation. It is the initiator side of the MAC interface. It holds N input/weight pairs in a small register file and issues them one at a time on `mac_x`/`mac_w`, feeding the running sum back through `mac_prev`. It captures `mac_out` once the MAC pipeline has settled, then applies a step threshold and reports `y` with a done pulse. It sits between the host load/start logic and the MAC datapath.

## Interface
- `N_INPUTS`, 4: number of x/w pairs per inference (1..16).
- `MAC_LATENCY`, 3: register stages from MAC operands to `mac_out`.
- `THRESH`, 8'd64: step activation threshold, unsigned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_en` in 1: write one pair into the register file.
- `load_addr` in $clog2(N_INPUTS) (min 1): register file index.
- `load_x` in 8: input value to store.
- `load_w` in 8: weight value to store.
- `start` in 1: begin inference; sampled only in IDLE.
- `mac_x` out 8: operand x to the MAC.
- `mac_w` out 8: operand w to the MAC.
- `mac_prev` out 8: running sum fed to the MAC `previous_out`.
- `mac_out` in 8: MAC result.
- `busy` out 1: high from the cycle after start is accepted until DONE completes.
- `done` out 1: one-cycle pulse when `y`/`y_acc` are updated.
- `y` out 1: activation, `y_acc >= THRESH`.
- `y_acc` out 8: final dot product, modulo 256.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `busy`=0. When `start`=1, set idx=0, cnt=0 and acc=0, register pair 0 onto `mac_x`/`mac_w`, set `mac_prev`=0, then go to RUN.
- RUN: operands stay stable for the whole step period P = MAC_LATENCY+1 cycles. cnt increments every cycle.
- When cnt==MAC_LATENCY:
  - acc <= `mac_out` and cnt <= 0.
  - If idx==N_INPUTS-1, go to DONE.
  - Otherwise idx++ and drive the next pair, with `mac_prev` <= the captured `mac_out`.
- DONE (1 cycle): `done`=1, `y_acc` <= acc, `y` <= (acc >= THRESH), then go to IDLE.
- Arithmetic: all 8-bit unsigned with wrap-around, matching the MAC. No saturation.
- `load_en` writes in IDLE only. While `busy`, writes are ignored and the register file is unchanged.
- `start` while `busy` or in DONE is ignored. There is no queuing.
- `load_en` and `start` in the same IDLE cycle: the write commits first, and the inference uses the new value.
- `rst` in any state:
  - Return to IDLE.
  - Clear the register file, acc, idx and cnt.
  - All outputs go to 0: `mac_x`, `mac_w`, `mac_prev`, `busy`, `done`, `y`, `y_acc`.
  - An in-flight inference is abandoned and produces no `done`.
- `y`/`y_acc` hold their value until the next DONE or reset.

## Timing
- All outputs are registered.
- If `start` is sampled at edge S:
  - Operands for pair 0 become valid after S.
  - `mac_out` is captured at edge S+P·(k+1) for pair k.
  - `done`=1 during the cycle after edge S+N_INPUTS·P.
  - With the defaults, `done` is observed 16 cycles after the start edge.
- `busy` rises after S and falls after the DONE cycle.
- The earliest accepted re-`start` is the cycle after `done`.

## Structure
- `perceptron_pkg` holds:
  - `DATA_W`=8.
  - The `seq_state_t` enum (IDLE, RUN, DONE).
  - A `pair_t` struct {x, w}, shared with future training and weight-update blocks.
- One natural sub-module is `perceptron_regfile`: an N_INPUTS×16-bit register file with a sync write port, an async read port and a synchronous clear on reset.
- The MAC is instantiated by the parent, not inside this block.

## Test plan
The bench uses a behavioural 3-stage MAC model.

- Load x={1,2,3,4}, w={2,2,2,2}, then start → `done` 16 cycles later, `y_acc`=20, `y`=0. `mac_prev` sequence is 0, 2, 6, 12.
- Load x={8,8,0,0}, w={4,4,0,0} → `y_acc`=64, `y`=1 (exact-threshold boundary). Change to w={4,3,0,0} → 56, `y`=0.
- Overflow: x={16,16,1,0}, w={16,16,5,0} → `y_acc`=5 (wrap twice), `y`=0.
- Pulse `start` again at cycles 3 and 10 of an active run, and pulse `load_en` to addr 0 mid-run → single `done`, result unchanged. A next run after `done` is accepted.
- Assert `rst` for 1 cycle at cycle 7 of a run → no `done`, all outputs 0 next cycle. Register file is cleared, so a subsequent start yields `y_acc`=0.
- Same-cycle `load_en` (addr 0, x=10, w=10) and `start` with the other pairs zero → `y_acc`=100, `y`=1.
